// File: rtl/core_9x8_pkg.sv
// Shared widths, opcode encodings and instruction decode helpers for the 9x8 stack core.
package core_9x8_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_FLOW = 2'b01,
    CLS_LIT  = 2'b10
  } instr_class_e;

  typedef enum logic [1:0] {
    FLOW_JUMP  = 2'b00,
    FLOW_JUMPC = 2'b01,
    FLOW_CALL  = 2'b10,
    FLOW_CALLC = 2'b11
  } flow_e;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00, OP_DUP   = 5'h01, OP_DROP  = 5'h02, OP_SWAP  = 5'h03,
    OP_OVER  = 5'h04, OP_ADD   = 5'h05, OP_SUB   = 5'h06, OP_AND   = 5'h07,
    OP_OR    = 5'h08, OP_XOR   = 5'h09, OP_INV   = 5'h0A, OP_SHL   = 5'h0B,
    OP_SHR   = 5'h0C, OP_ZEQ   = 5'h0D, OP_TO_R  = 5'h0E, OP_R_FROM = 5'h0F,
    OP_RET   = 5'h10, OP_FETCH = 5'h11, OP_STORE = 5'h12, OP_HALT  = 5'h13
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  function automatic instr_class_e decode_class(input logic [1:0] hi);
    if (hi[1]) return CLS_LIT;
    if (hi[0]) return CLS_FLOW;
    return CLS_ALU;
  endfunction

  // Codes above 0x13 in the ALU space execute as nop.
  function automatic op_e decode_op(input logic [6:0] code);
    if (code[6:5] == 2'b00 && code[4:0] <= 5'h13) return op_e'(code[4:0]);
    return OP_NOP;
  endfunction

endpackage

// File: rtl/core_9x8_stack.sv
// Wrapping LIFO below a register-held top: push writes slot ptr+1, pops read slot ptr (and ptr-1).
module core_9x8_stack
  import core_9x8_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             pop2,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (push)      ptr_d = ptr_q + PTR_W'(1);
    else if (pop2) ptr_d = ptr_q - PTR_W'(2);
    else if (pop)  ptr_d = ptr_q - PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Contents survive reset; wrap overwrites the oldest slot silently.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q + PTR_W'(1)] <= din;
  end

  assign top  = mem_q[ptr_q];
  assign next = mem_q[ptr_q - PTR_W'(1)];

endmodule

// File: rtl/core_9x8.sv
// 9-bit-instruction / 8-bit-data stack processor; one instruction per clock until HALT.
// Define CORE_TRACE_EN to print a per-instruction execution trace.
module core_9x8
  import core_9x8_pkg::*;
#(
  parameter string       G_PROG_FILE = "core.mem",
  parameter int unsigned C_PC_WIDTH  = 8,
  parameter int unsigned C_DS_DEPTH  = 16,
  parameter int unsigned C_RS_DEPTH  = 16,
  parameter int unsigned C_MEM_DEPTH = 32
) (
  input logic i_clk,
  input logic i_rst
);

  localparam int unsigned MEM_AW = $clog2(C_MEM_DEPTH);

  logic [INSTR_W-1:0]    rom [2**C_PC_WIDTH];
  logic [DATA_W-1:0]     mem_q [C_MEM_DEPTH];

  logic [C_PC_WIDTH-1:0] pc_q, pc_d, pc_inc, target;
  logic [DATA_W-1:0]     t_q, t_d, n_q, n_d;
  run_state_e            state_q, state_d;

  logic [INSTR_W-1:0]    instr;
  instr_class_e          cls;
  op_e                   op;
  logic [MEM_AW-1:0]     mem_addr;
  logic                  mem_we;

  logic                  ds_push, ds_pop, ds_pop2;
  logic [DATA_W-1:0]     ds_top, ds_next;
  logic                  rs_push, rs_pop;
  logic [C_PC_WIDTH-1:0] rs_din, rs_top, rs_next_unused;

  assign instr    = rom[pc_q];
  assign cls      = decode_class(instr[8:7]);
  assign op       = decode_op(instr[6:0]);
  assign pc_inc   = pc_q + C_PC_WIDTH'(1);
  assign target   = C_PC_WIDTH'(t_q);
  assign mem_addr = MEM_AW'(t_q);

  always_comb begin
    pc_d    = pc_q;
    t_d     = t_q;
    n_d     = n_q;
    state_d = state_q;
    ds_push = 1'b0;
    ds_pop  = 1'b0;
    ds_pop2 = 1'b0;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    rs_din  = pc_inc;
    mem_we  = 1'b0;
    if (state_q == ST_RUN) begin
      pc_d = pc_inc;
      unique case (cls)
        CLS_LIT: begin
          t_d = instr[7:0]; n_d = t_q; ds_push = 1'b1;
        end
        CLS_FLOW: begin
          unique case (flow_e'(instr[1:0]))
            FLOW_JUMP: begin
              pc_d = target; t_d = n_q; n_d = ds_top; ds_pop = 1'b1;
            end
            FLOW_CALL: begin
              pc_d = target; rs_push = 1'b1;
              t_d = n_q; n_d = ds_top; ds_pop = 1'b1;
            end
            FLOW_JUMPC: begin
              if (n_q != '0) pc_d = target;
              t_d = ds_top; n_d = ds_next; ds_pop2 = 1'b1;
            end
            FLOW_CALLC: begin
              if (n_q != '0) begin
                pc_d = target; rs_push = 1'b1;
              end
              t_d = ds_top; n_d = ds_next; ds_pop2 = 1'b1;
            end
          endcase
        end
        default: begin
          case (op)
            OP_DUP:  begin n_d = t_q; ds_push = 1'b1; end
            OP_DROP: begin t_d = n_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_SWAP: begin t_d = n_q; n_d = t_q; end
            OP_OVER: begin t_d = n_q; n_d = t_q; ds_push = 1'b1; end
            OP_ADD:  begin t_d = n_q + t_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_SUB:  begin t_d = n_q - t_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_AND:  begin t_d = n_q & t_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_OR:   begin t_d = n_q | t_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_XOR:  begin t_d = n_q ^ t_q; n_d = ds_top; ds_pop = 1'b1; end
            OP_INV:  t_d = ~t_q;
            OP_SHL:  t_d = {t_q[6:0], 1'b0};
            OP_SHR:  t_d = {1'b0, t_q[7:1]};
            OP_ZEQ:  t_d = (t_q == '0) ? '1 : '0;
            OP_TO_R: begin
              rs_din = C_PC_WIDTH'(t_q); rs_push = 1'b1;
              t_d = n_q; n_d = ds_top; ds_pop = 1'b1;
            end
            OP_R_FROM: begin
              t_d = DATA_W'(rs_top); n_d = t_q; ds_push = 1'b1; rs_pop = 1'b1;
            end
            OP_RET:   begin pc_d = rs_top; rs_pop = 1'b1; end
            OP_FETCH: t_d = mem_q[mem_addr];
            OP_STORE: begin
              mem_we = 1'b1; t_d = ds_top; n_d = ds_next; ds_pop2 = 1'b1;
            end
            OP_HALT:  begin pc_d = pc_q; state_d = ST_HALT; end
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q    <= '0;
      t_q     <= '0;
      n_q     <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      t_q     <= t_d;
      n_q     <= n_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_addr] <= n_q;
  end

  core_9x8_stack #(.DEPTH(C_DS_DEPTH), .WIDTH(DATA_W)) u_ds (
    .clk  (i_clk),
    .rst_n(i_rst),
    .push (ds_push),
    .pop  (ds_pop),
    .pop2 (ds_pop2),
    .din  (n_q),
    .top  (ds_top),
    .next (ds_next)
  );

  core_9x8_stack #(.DEPTH(C_RS_DEPTH), .WIDTH(C_PC_WIDTH)) u_rs (
    .clk  (i_clk),
    .rst_n(i_rst),
    .push (rs_push),
    .pop  (rs_pop),
    .pop2 (1'b0),
    .din  (rs_din),
    .top  (rs_top),
    .next (rs_next_unused)
  );

`ifdef CORE_TRACE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst && state_q == ST_RUN) begin
      $write("pc=%h op=%h T=%h N=%h\n", pc_q, instr, t_q, n_q);
      if (cls == CLS_ALU && op == OP_HALT) $write("HALT\n");
    end
  end
`endif

endmodule

// File: tb/tb_core_9x8.sv
// Directed bench for core_9x8: programs are poked into the ROM, results observed hierarchically.
module tb_core_9x8;
  import core_9x8_pkg::*;

  localparam logic [8:0] I_HALT  = 9'h013;
  localparam logic [8:0] I_DROP  = 9'h002;
  localparam logic [8:0] I_STORE = 9'h012;
  localparam logic [8:0] I_FETCH = 9'h011;
  localparam logic [8:0] I_RET   = 9'h010;
  localparam logic [8:0] I_TO_R  = 9'h00E;
  localparam logic [8:0] I_RFROM = 9'h00F;
  localparam logic [8:0] I_ADD   = 9'h005;
  localparam logic [8:0] I_JUMP  = 9'h080;
  localparam logic [8:0] I_JUMPC = 9'h081;
  localparam logic [8:0] I_CALL  = 9'h082;
  localparam logic [8:0] I_CALLC = 9'h083;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  typedef struct {
    logic [8:0] op;
    logic [7:0] a, b, exp_t, exp_n;
    logic [3:0] exp_p;
  } vec_t;
  vec_t vecs[17];

  core_9x8 #(.G_PROG_FILE("")) dut (
    .i_clk(clk),
    .i_rst(rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] lit(input logic [7:0] v);
    return {1'b1, v};
  endfunction

  task automatic put(input int addr, input logic [8:0] w);
    dut.rom[addr] = w;
  endtask

  task automatic begin_prog();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.rom[i] = I_HALT;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == ST_HALT) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic load_add_prog();
    begin_prog();
    put(0, lit(8'h03)); put(1, lit(8'h04)); put(2, I_ADD); put(3, I_HALT);
  endtask

  initial begin
    vecs[0]  = '{9'h005, 8'hF0, 8'h20, 8'h10, 8'h00, 4'd1};
    vecs[1]  = '{9'h006, 8'h05, 8'h07, 8'hFE, 8'h00, 4'd1};
    vecs[2]  = '{9'h007, 8'hCC, 8'hAA, 8'h88, 8'h00, 4'd1};
    vecs[3]  = '{9'h008, 8'hCC, 8'hAA, 8'hEE, 8'h00, 4'd1};
    vecs[4]  = '{9'h009, 8'hCC, 8'hAA, 8'h66, 8'h00, 4'd1};
    vecs[5]  = '{9'h00A, 8'hCC, 8'h5A, 8'hA5, 8'hCC, 4'd2};
    vecs[6]  = '{9'h00B, 8'hCC, 8'h81, 8'h02, 8'hCC, 4'd2};
    vecs[7]  = '{9'h00C, 8'hCC, 8'h81, 8'h40, 8'hCC, 4'd2};
    vecs[8]  = '{9'h00D, 8'hCC, 8'h00, 8'hFF, 8'hCC, 4'd2};
    vecs[9]  = '{9'h00D, 8'hCC, 8'h01, 8'h00, 8'hCC, 4'd2};
    vecs[10] = '{9'h001, 8'h12, 8'h34, 8'h34, 8'h34, 4'd3};
    vecs[11] = '{9'h002, 8'h12, 8'h34, 8'h12, 8'h00, 4'd1};
    vecs[12] = '{9'h003, 8'h12, 8'h34, 8'h12, 8'h34, 4'd2};
    vecs[13] = '{9'h004, 8'h12, 8'h34, 8'h12, 8'h34, 4'd3};
    vecs[14] = '{9'h000, 8'h12, 8'h34, 8'h34, 8'h12, 4'd2};
    vecs[15] = '{9'h07F, 8'h12, 8'h34, 8'h34, 8'h12, 4'd2};
    vecs[16] = '{9'h014, 8'h12, 8'h34, 8'h34, 8'h12, 4'd2};

    // Case 1: 3 + 4, halt holds pc and state
    load_add_prog();
    check("rst_pc", 16'(dut.pc_q), 16'h0);
    check("rst_T", 16'(dut.t_q), 16'h0);
    check("rst_halted", 16'(dut.state_q == ST_HALT), 16'h0);
    release_rst();
    run_to_halt(20, cyc);
    check("add_cycles", 16'(cyc), 16'd4);
    check("add_T", 16'(dut.t_q), 16'h07);
    check("add_N", 16'(dut.n_q), 16'h00);
    check("add_pc", 16'(dut.pc_q), 16'h03);
    step(3);
    check("halt_pc_frozen", 16'(dut.pc_q), 16'h03);
    check("halt_T_frozen", 16'(dut.t_q), 16'h07);
    check("halt_dsp_frozen", 16'(dut.u_ds.ptr_q), 16'h1);

    // ALU / stack-shuffle table
    for (int i = 0; i < 17; i++) begin
      begin_prog();
      put(0, lit(vecs[i].a)); put(1, lit(vecs[i].b)); put(2, vecs[i].op);
      release_rst();
      run_to_halt(20, cyc);
      check($sformatf("vec%0d_cycles", i), 16'(cyc), 16'd4);
      check($sformatf("vec%0d_T", i), 16'(dut.t_q), 16'(vecs[i].exp_t));
      check($sformatf("vec%0d_N", i), 16'(dut.n_q), 16'(vecs[i].exp_n));
      check($sformatf("vec%0d_dsp", i), 16'(dut.u_ds.ptr_q), 16'(vecs[i].exp_p));
    end

    // Case 2: jumpc not taken then taken
    begin_prog();
    put(0, lit(8'h00)); put(1, lit(8'h10)); put(2, I_JUMPC);
    put(3, lit(8'h01)); put(4, lit(8'h10)); put(5, I_JUMPC);
    put(6, lit(8'hEE));
    release_rst();
    step(3);
    check("jumpc_nt_pc", 16'(dut.pc_q), 16'h03);
    check("jumpc_nt_dsp", 16'(dut.u_ds.ptr_q), 16'h0);
    run_to_halt(20, cyc);
    check("jumpc_t_cycles", 16'(cyc), 16'd4);
    check("jumpc_t_pc", 16'(dut.pc_q), 16'h10);
    check("jumpc_t_dsp", 16'(dut.u_ds.ptr_q), 16'h0);

    // Case 3: call / return
    begin_prog();
    put(0, lit(8'h20)); put(1, I_CALL);
    put(8'h20, lit(8'h55)); put(8'h21, I_RET);
    release_rst();
    step(2);
    check("call_pc", 16'(dut.pc_q), 16'h20);
    check("call_rsp", 16'(dut.u_rs.ptr_q), 16'h1);
    run_to_halt(20, cyc);
    check("ret_cycles", 16'(cyc), 16'd3);
    check("ret_pc", 16'(dut.pc_q), 16'h02);
    check("ret_T", 16'(dut.t_q), 16'h55);
    check("ret_rsp", 16'(dut.u_rs.ptr_q), 16'h0);

    // Case 4: store / fetch, address wraps mod 32
    begin_prog();
    put(0, lit(8'h33)); put(1, lit(8'h06)); put(2, I_STORE);
    put(3, lit(8'hAA)); put(4, lit(8'h05)); put(5, I_STORE);
    put(6, lit(8'h25)); put(7, I_FETCH);
    put(8, lit(8'h06)); put(9, I_FETCH);
    release_rst();
    step(8);
    check("fetch_wrap_T", 16'(dut.t_q), 16'hAA);
    run_to_halt(20, cyc);
    check("mem_cycles", 16'(cyc), 16'd3);
    check("fetch6_T", 16'(dut.t_q), 16'h33);
    check("fetch_N", 16'(dut.n_q), 16'hAA);
    check("mem5", 16'(dut.mem_q[5]), 16'hAA);
    check("mem6_kept", 16'(dut.mem_q[6]), 16'h33);

    // Case 5: 17 pushes wrap the 16-deep stack, 17 drops read stale slots
    begin_prog();
    for (int k = 0; k < 17; k++) put(k, lit(8'(k)));
    for (int k = 17; k < 34; k++) put(k, I_DROP);
    release_rst();
    step(17);
    check("wrap_push_T", 16'(dut.t_q), 16'h10);
    check("wrap_push_N", 16'(dut.n_q), 16'h0F);
    check("wrap_push_dsp", 16'(dut.u_ds.ptr_q), 16'h1);
    run_to_halt(40, cyc);
    check("wrap_cycles", 16'(cyc), 16'd18);
    check("wrap_drop_T", 16'(dut.t_q), 16'h00);
    check("wrap_drop_N", 16'(dut.n_q), 16'h0E);
    check("wrap_drop_dsp", 16'(dut.u_ds.ptr_q), 16'h0);
    check("wrap_pc", 16'(dut.pc_q), 16'h22);

    // Return-stack transfer plus callc / jump
    begin_prog();
    put(0, lit(8'h12)); put(1, I_TO_R); put(2, lit(8'h34)); put(3, I_RFROM);
    put(4, lit(8'h01)); put(5, lit(8'h30)); put(6, I_CALLC);
    put(7, lit(8'h0A)); put(8, I_JUMP); put(9, lit(8'h77));
    put(8'h30, I_RET);
    release_rst();
    step(4);
    check("rfrom_T", 16'(dut.t_q), 16'h12);
    check("rfrom_N", 16'(dut.n_q), 16'h34);
    check("rfrom_rsp", 16'(dut.u_rs.ptr_q), 16'h0);
    step(3);
    check("callc_pc", 16'(dut.pc_q), 16'h30);
    run_to_halt(20, cyc);
    check("flow_cycles", 16'(cyc), 16'd4);
    check("jump_pc", 16'(dut.pc_q), 16'h0A);
    check("flow_rsp", 16'(dut.u_rs.ptr_q), 16'h0);

    // Case 6: asynchronous reset between edges, then clean restart
    load_add_prog();
    release_rst();
    step(2);
    check("pre_rst_T", 16'(dut.t_q), 16'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", 16'(dut.pc_q), 16'h0);
    check("async_T", 16'(dut.t_q), 16'h0);
    check("async_N", 16'(dut.n_q), 16'h0);
    check("async_dsp", 16'(dut.u_ds.ptr_q), 16'h0);
    release_rst();
    run_to_halt(20, cyc);
    check("rerun_cycles", 16'(cyc), 16'd4);
    check("rerun_T", 16'(dut.t_q), 16'h07);
    check("rerun_pc", 16'(dut.pc_q), 16'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
